// File: rtl/pcie_ltssm_pkg.sv
// Shared LTSSM encodings, link-state enum and small helpers for the
// PCIe link-event logic.
package pcie_ltssm_pkg;

  localparam logic [4:0] LTSSM_L0         = 5'h0F;
  localparam logic [4:0] LTSSM_DISABLE    = 5'h10;
  localparam logic [4:0] LTSSM_HOT_RESET  = 5'h14;
  localparam logic [4:0] LTSSM_L2_IDLE    = 5'h18;
  localparam logic [4:0] LTSSM_L2_TX_WAKE = 5'h19;

  typedef enum logic [1:0] {
    ST_DOWN   = 2'd0,
    ST_UP     = 2'd1,
    ST_HOTRST = 2'd2,
    ST_L2     = 2'd3
  } link_state_e;

  function automatic logic is_l2(input logic [4:0] s);
    return (s == LTSSM_L2_IDLE) || (s == LTSSM_L2_TX_WAKE);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pcie_exit_pulse.sv
// Active-low exit strobe: a fire (re)loads a down-counter and the output
// stays low while the counter is nonzero, so back-to-back fires extend it.
module pcie_exit_pulse #(
  parameter int unsigned PULSE_W = 2
) (
  input  logic pld_clk,
  input  logic any_rstn_rr,
  input  logic fire,
  output logic exit_n
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fire) begin
      cnt_d = 4'(PULSE_W);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
    if (!any_rstn_rr) cnt_q <= '0;
    else              cnt_q <= cnt_d;
  end

  // Driven straight from the counter so reset raises the strobe at once.
  assign exit_n = (cnt_q == 4'd0);

endmodule

// File: rtl/pcie_link_exit_gen.sv
// Debounces the HIP LTSSM, tracks link state and emits the active-low
// dlup/hotrst/l2 exit strobes. Define PCIE_LINK_EVT_CNT_EN for event counters.
module pcie_link_exit_gen
  import pcie_ltssm_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned PULSE_W    = 2
) (
  input  logic       pld_clk,
  input  logic       any_rstn_rr,
  input  logic [4:0] ltssm,
  input  logic       dl_up,
`ifdef PCIE_LINK_EVT_CNT_EN
  input  logic       evt_cnt_clr,
`endif
  output logic       dlup_exit,
  output logic       hotrst_exit,
  output logic       l2_exit,
  output logic       link_up,
  output logic [4:0] ltssm_stable,
  output logic [1:0] fsm_state_dbg
`ifdef PCIE_LINK_EVT_CNT_EN
  ,
  output logic [7:0] evt_dlup_cnt,
  output logic [7:0] evt_hotrst_cnt,
  output logic [7:0] evt_l2_cnt
`endif
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYC);

  logic [4:0]  ltssm_r_q;
  logic        dl_up_r_q;
  logic [4:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  stable_q, stable_d;
  link_state_e state_q;
  logic        link_up_q;
  logic        fire_dlup_q, fire_hotrst_q, fire_l2_q;

  // Acceptance uses the next count so a steady input lands at edge k+STABLE_CYC.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (ltssm_r_q != cand_q) begin
      cand_d = ltssm_r_q;
      cnt_d  = 4'd1;
    end else if (cnt_q != STABLE_N) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (cnt_d == STABLE_N) stable_d = cand_d;
  end

  always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
    if (!any_rstn_rr) begin
      ltssm_r_q <= '0;
      dl_up_r_q <= 1'b0;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
    end else begin
      ltssm_r_q <= ltssm;
      dl_up_r_q <= dl_up;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
    end
  end

  always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
    if (!any_rstn_rr) begin
      state_q       <= ST_DOWN;
      link_up_q     <= 1'b0;
      fire_dlup_q   <= 1'b0;
      fire_hotrst_q <= 1'b0;
      fire_l2_q     <= 1'b0;
    end else begin
      fire_dlup_q   <= 1'b0;
      fire_hotrst_q <= 1'b0;
      fire_l2_q     <= 1'b0;
      link_up_q     <= (state_q == ST_UP);
      case (state_q)
        ST_DOWN: begin
          if (stable_q == LTSSM_L0 && dl_up_r_q) state_q <= ST_UP;
        end
        ST_UP: begin
          // Losing the data link outranks every LTSSM-driven exit.
          if (!dl_up_r_q) begin
            state_q     <= ST_DOWN;
            fire_dlup_q <= 1'b1;
          end else if (stable_q == LTSSM_HOT_RESET) begin
            state_q <= ST_HOTRST;
          end else if (is_l2(stable_q)) begin
            state_q <= ST_L2;
          end else if (stable_q == LTSSM_DISABLE) begin
            state_q <= ST_DOWN;
          end
        end
        ST_HOTRST: begin
          if (stable_q != LTSSM_HOT_RESET) begin
            state_q       <= ST_DOWN;
            fire_hotrst_q <= 1'b1;
          end
        end
        ST_L2: begin
          if (!is_l2(stable_q)) begin
            state_q   <= ST_DOWN;
            fire_l2_q <= 1'b1;
          end
        end
        default: state_q <= ST_DOWN;
      endcase
    end
  end

  pcie_exit_pulse #(.PULSE_W(PULSE_W)) u_dlup_pulse (
    .pld_clk(pld_clk), .any_rstn_rr(any_rstn_rr),
    .fire(fire_dlup_q), .exit_n(dlup_exit)
  );

  pcie_exit_pulse #(.PULSE_W(PULSE_W)) u_hotrst_pulse (
    .pld_clk(pld_clk), .any_rstn_rr(any_rstn_rr),
    .fire(fire_hotrst_q), .exit_n(hotrst_exit)
  );

  pcie_exit_pulse #(.PULSE_W(PULSE_W)) u_l2_pulse (
    .pld_clk(pld_clk), .any_rstn_rr(any_rstn_rr),
    .fire(fire_l2_q), .exit_n(l2_exit)
  );

  assign link_up       = link_up_q;
  assign ltssm_stable  = stable_q;
  assign fsm_state_dbg = state_q;

`ifdef PCIE_LINK_EVT_CNT_EN
  logic [7:0] dlup_cnt_q, dlup_cnt_d;
  logic [7:0] hotrst_cnt_q, hotrst_cnt_d;
  logic [7:0] l2_cnt_q, l2_cnt_d;

  // A clear outranks an increment arriving in the same cycle.
  always_comb begin
    dlup_cnt_d   = dlup_cnt_q;
    hotrst_cnt_d = hotrst_cnt_q;
    l2_cnt_d     = l2_cnt_q;
    if (evt_cnt_clr) begin
      dlup_cnt_d   = '0;
      hotrst_cnt_d = '0;
      l2_cnt_d     = '0;
    end else begin
      if (fire_dlup_q)   dlup_cnt_d   = sat_inc8(dlup_cnt_q);
      if (fire_hotrst_q) hotrst_cnt_d = sat_inc8(hotrst_cnt_q);
      if (fire_l2_q)     l2_cnt_d     = sat_inc8(l2_cnt_q);
    end
  end

  always_ff @(posedge pld_clk or negedge any_rstn_rr) begin
    if (!any_rstn_rr) begin
      dlup_cnt_q   <= '0;
      hotrst_cnt_q <= '0;
      l2_cnt_q     <= '0;
    end else begin
      dlup_cnt_q   <= dlup_cnt_d;
      hotrst_cnt_q <= hotrst_cnt_d;
      l2_cnt_q     <= l2_cnt_d;
    end
  end

  assign evt_dlup_cnt   = dlup_cnt_q;
  assign evt_hotrst_cnt = hotrst_cnt_q;
  assign evt_l2_cnt     = l2_cnt_q;
`endif

endmodule

// File: tb/tb_pcie_link_exit_gen.sv
// Directed bench for pcie_link_exit_gen: vector table plus hand-written
// timing sequences; strobe pulses are checked against an expected queue.
module tb_pcie_link_exit_gen;

  localparam int PW = 2;

  logic       pld_clk = 1'b0;
  logic       any_rstn_rr = 1'b0;
  logic [4:0] ltssm = 5'h0F;
  logic       dl_up = 1'b1;
  logic       dlup_exit, hotrst_exit, l2_exit, link_up;
  logic [4:0] ltssm_stable;
  logic [1:0] fsm_state_dbg;
`ifdef PCIE_LINK_EVT_CNT_EN
  logic       evt_cnt_clr = 1'b0;
  logic [7:0] evt_dlup_cnt, evt_hotrst_cnt, evt_l2_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  pcie_link_exit_gen dut (
    .pld_clk       (pld_clk),
    .any_rstn_rr   (any_rstn_rr),
    .ltssm         (ltssm),
    .dl_up         (dl_up),
`ifdef PCIE_LINK_EVT_CNT_EN
    .evt_cnt_clr   (evt_cnt_clr),
    .evt_dlup_cnt  (evt_dlup_cnt),
    .evt_hotrst_cnt(evt_hotrst_cnt),
    .evt_l2_cnt    (evt_l2_cnt),
`endif
    .dlup_exit     (dlup_exit),
    .hotrst_exit   (hotrst_exit),
    .l2_exit       (l2_exit),
    .link_up       (link_up),
    .ltssm_stable  (ltssm_stable),
    .fsm_state_dbg (fsm_state_dbg)
  );

  // Clock / reset
  always #5 pld_clk = ~pld_clk;
  always @(posedge pld_clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation ran past 1ms");
    $fatal(1, "timeout");
  end

  // Scoreboard: each pulse is {id, width, start cycle}; id 1=dlup 2=hotrst 3=l2
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic [2:0]  prev_n = 3'b111;
  int          p_width[3];
  int          p_start[3];

  function automatic logic [23:0] pk(input int id, input int w, input int s);
    return {2'(id), 6'(w), 16'(s)};
  endfunction

  always @(negedge pld_clk) begin
    logic [2:0] cur;
    cur = {l2_exit, hotrst_exit, dlup_exit};
    for (int i = 0; i < 3; i++) begin
      if (!cur[i]) begin
        if (prev_n[i]) begin
          p_start[i] = cyc;
          p_width[i] = 0;
        end
        p_width[i]++;
      end else if (!prev_n[i]) begin
        obs_q.push_back(pk(i + 1, p_width[i], p_start[i]));
      end
    end
    prev_n = cur;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pld_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_pulses(input string name);
    chk({name, " pulse count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({name, " pulse {id,w,start}"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  typedef struct {
    logic [4:0] lt;
    logic       dl;
    int         hold;
    logic       exp_up;
    logic [4:0] exp_st;
    int         pid;
    int         pofs;
  } vec_t;

  vec_t vt[15];

  initial begin
    int e0;

    vt[0]  = '{5'h0F, 1'b1, 10, 1'b1, 5'h0F, 0, 0};
    vt[1]  = '{5'h10, 1'b1, 10, 1'b0, 5'h10, 0, 0};
    vt[2]  = '{5'h0F, 1'b1, 12, 1'b1, 5'h0F, 0, 0};
    vt[3]  = '{5'h0F, 1'b0, 10, 1'b0, 5'h0F, 1, 3};
    vt[4]  = '{5'h0F, 1'b1, 10, 1'b1, 5'h0F, 0, 0};
    vt[5]  = '{5'h07, 1'b1, 10, 1'b1, 5'h07, 0, 0};
    vt[6]  = '{5'h0F, 1'b1, 10, 1'b1, 5'h0F, 0, 0};
    vt[7]  = '{5'h18, 1'b1, 10, 1'b0, 5'h18, 0, 0};
    vt[8]  = '{5'h19, 1'b1, 10, 1'b0, 5'h19, 0, 0};
    vt[9]  = '{5'h00, 1'b0, 10, 1'b0, 5'h00, 3, 7};
    vt[10] = '{5'h0F, 1'b1, 10, 1'b1, 5'h0F, 0, 0};
    vt[11] = '{5'h14, 1'b1, 10, 1'b0, 5'h14, 0, 0};
    vt[12] = '{5'h0F, 1'b1, 12, 1'b1, 5'h0F, 2, 7};
    vt[13] = '{5'h14, 1'b0, 10, 1'b0, 5'h14, 1, 3};
    vt[14] = '{5'h0F, 1'b1, 10, 1'b1, 5'h0F, 0, 0};

    // Reset state and release timing
    tick(3);
    chk("rst strobes", {l2_exit, hotrst_exit, dlup_exit}, 3'b111);
    chk("rst link_up", link_up, 1'b0);
    chk("rst ltssm_stable", ltssm_stable, 5'h00);
    chk("rst state", fsm_state_dbg, 2'd0);
    any_rstn_rr = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick(1);
      chk($sformatf("release stable j=%0d", j), ltssm_stable, (j >= 4) ? 5'h0F : 5'h00);
      chk($sformatf("release link_up j=%0d", j), link_up, (j >= 6) ? 1'b1 : 1'b0);
    end
    chk("release strobes", {l2_exit, hotrst_exit, dlup_exit}, 3'b111);
    chk_pulses("release");

    // Table-driven vectors
    for (int v = 0; v < 15; v++) begin
      e0 = cyc;
      ltssm = vt[v].lt;
      dl_up = vt[v].dl;
      if (vt[v].pid != 0) exp_q.push_back(pk(vt[v].pid, PW, e0 + vt[v].pofs));
      tick(vt[v].hold);
      chk($sformatf("vec%0d link_up", v), link_up, vt[v].exp_up);
      chk($sformatf("vec%0d stable", v), ltssm_stable, vt[v].exp_st);
    end
    tick(4);
    chk_pulses("table");

    // dl_up drop: cycle-exact strobe window
    e0 = cyc;
    dl_up = 1'b0;
    exp_q.push_back(pk(1, PW, e0 + 3));
    for (int j = 1; j <= 6; j++) begin
      tick(1);
      chk($sformatf("dlup strobe j=%0d", j), dlup_exit, (j == 3 || j == 4) ? 1'b0 : 1'b1);
      chk($sformatf("dlup link_up j=%0d", j), link_up, (j < 3) ? 1'b1 : 1'b0);
    end
    tick(4);
    dl_up = 1'b1;
    tick(10);
    chk("dlup relink", link_up, 1'b1);
    chk_pulses("dlup");

    // Hot reset with dl_up falling inside it
    ltssm = 5'h14;
    tick(10);
    dl_up = 1'b0;
    tick(10);
    ltssm = 5'h00;
    e0 = cyc;
    exp_q.push_back(pk(2, PW, e0 + 7));
    tick(6);
    chk("hotrst pre", hotrst_exit, 1'b1);
    tick(1);
    chk("hotrst low1", hotrst_exit, 1'b0);
    tick(1);
    chk("hotrst low2", hotrst_exit, 1'b0);
    tick(1);
    chk("hotrst end", hotrst_exit, 1'b1);
    tick(3);
    chk_pulses("hotrst");
    ltssm = 5'h0F;
    dl_up = 1'b1;
    tick(10);
    chk("hotrst relink", link_up, 1'b1);

    // Three-sample glitch never reaches the debounced state
    ltssm = 5'h14;
    tick(3);
    ltssm = 5'h0F;
    for (int j = 0; j < 8; j++) begin
      tick(1);
      chk($sformatf("glitch stable j=%0d", j), ltssm_stable, 5'h0F);
    end
    chk("glitch link_up", link_up, 1'b1);
    chk_pulses("glitch");

    // L2_IDLE -> L2_TX_WAKE -> exit: a single l2 pulse
    ltssm = 5'h18;
    tick(8);
    ltssm = 5'h19;
    tick(8);
    ltssm = 5'h00;
    e0 = cyc;
    exp_q.push_back(pk(3, PW, e0 + 7));
    tick(12);
    chk("l2 link_up", link_up, 1'b0);
    chk_pulses("l2");
    ltssm = 5'h0F;
    tick(10);

    // dl_up fall coincides with HOT_RESET acceptance: dlup wins
    e0 = cyc;
    ltssm = 5'h14;
    tick(4);
    dl_up = 1'b0;
    exp_q.push_back(pk(1, PW, e0 + 7));
    tick(12);
    chk("simul link_up", link_up, 1'b0);
    chk("simul state", fsm_state_dbg, 2'd0);
    chk_pulses("simul");
    ltssm = 5'h0F;
    dl_up = 1'b1;
    tick(10);

    // Asynchronous reset mid-pulse raises the strobe immediately
    dl_up = 1'b0;
    tick(3);
    chk("async pre low", dlup_exit, 1'b0);
    #1 any_rstn_rr = 1'b0;
    #1;
    chk("async strobe high", dlup_exit, 1'b1);
    chk("async link_up", link_up, 1'b0);
    chk("async stable", ltssm_stable, 5'h00);
    dl_up = 1'b1;
    tick(2);
    any_rstn_rr = 1'b1;
    tick(12);
    chk("async relink", link_up, 1'b1);
    chk_pulses("async");

`ifdef PCIE_LINK_EVT_CNT_EN
    // Saturation after 300 dlup events, then clear beats a coincident fire
    for (int n = 0; n < 300; n++) begin
      dl_up = 1'b0;
      tick(4);
      dl_up = 1'b1;
      tick(4);
    end
    tick(4);
    chk("cnt dlup sat", evt_dlup_cnt, 8'd255);
    chk("cnt hotrst", evt_hotrst_cnt, 8'd0);
    chk("cnt l2", evt_l2_cnt, 8'd0);
    dl_up = 1'b0;
    tick(2);
    evt_cnt_clr = 1'b1;
    tick(1);
    evt_cnt_clr = 1'b0;
    chk("cnt clr wins", evt_dlup_cnt, 8'd0);
    tick(2);
    dl_up = 1'b1;
    tick(6);
    dl_up = 1'b0;
    tick(4);
    chk("cnt after clr", evt_dlup_cnt, 8'd1);
    tick(4);
    exp_q.delete();
    obs_q.delete();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_link_exit_gen.md
# pcie_link_exit_gen

Link-event generator for the PCIe hard-IP application interface. It watches the HIP LTSSM state and the data-link-up flag, debounces the LTSSM, and tracks link state in a small FSM. It produces the active-low, pulse-stretched exit strobes (dlup_exit, hotrst_exit, l2_exit) that the HIP reset controller consumes, and so is the source side of that reset-event interface. It sits in the pld_clk domain between the HIP status outputs and the reset controller.

## Interface
- STABLE_CYC, 4: consecutive identical LTSSM samples needed to accept a new state; legal range 1..15.
- PULSE_W, 2: low width of each exit strobe in cycles; legal range 1..15.
- pld_clk  in  1  application clock; all logic is on its rising edge.
- any_rstn_rr  in  1  asynchronous, active-low reset.
- ltssm  in  5  raw HIP LTSSM state.
- dl_up  in  1  HIP data-link-up flag.
- evt_cnt_clr  in  1  synchronous clear of the event counters (counter build only).
- dlup_exit  out  1  active-low strobe: link lost while in L0.
- hotrst_exit  out  1  active-low strobe: hot reset completed.
- l2_exit  out  1  active-low strobe: L2 exited.
- link_up  out  1  FSM is in UP.
- ltssm_stable  out  5  debounced LTSSM.
- evt_dlup_cnt, evt_hotrst_cnt, evt_l2_cnt  out  8 each  saturating event counts (counter build only).

## Operation
- Stage 1 registers ltssm_r <= ltssm and dl_up_r <= dl_up.
- Debounce uses cand (5 b) and cnt (4 b), with cnt saturating at STABLE_CYC.
  - If ltssm_r != cand: cand <= ltssm_r and cnt <= 1.
  - Otherwise cnt increments.
  - When cnt == STABLE_CYC and ltssm_stable != cand: ltssm_stable <= cand.
- FSM states are DOWN, UP, HOTRST and L2. Reset state is DOWN.
  - DOWN -> UP when ltssm_stable == L0 (5'h0F) and dl_up_r == 1.
  - UP, priority order:
    1. dl_up_r == 0 -> DOWN and fire dlup.
    2. ltssm_stable == HOT_RESET (5'h14) -> HOTRST.
    3. ltssm_stable in {L2_IDLE 5'h18, L2_TX_WAKE 5'h19} -> L2.
    4. ltssm_stable == DISABLE (5'h10) -> DOWN with no strobe; the reset controller decodes DISABLE itself.
  - HOTRST ignores dl_up_r. When ltssm_stable != HOT_RESET: -> DOWN and fire hotrst.
  - L2: when ltssm_stable is not L2_IDLE or L2_TX_WAKE: -> DOWN and fire l2.
- link_up is registered and is 1 only while the state is UP.
- Each strobe has its own pulse counter.
  - A fire loads the counter with PULSE_W. The strobe output is low while the counter is nonzero, and the counter decrements each cycle.
  - A fire while a pulse is still active reloads the counter to PULSE_W, which extends the pulse.
- At most one fire per cycle is possible because each fire is tied to a distinct FSM exit.

## Timing
- Reset values: dlup_exit, hotrst_exit and l2_exit = 1; link_up = 0; ltssm_stable = 0; cand = 0; cnt = 0; state = DOWN; counters = 0.
- Asserting any_rstn_rr mid-pulse forces the strobes high immediately (asynchronously).
- LTSSM latency:
  - Input first sampled at edge k.
  - cand loaded at edge k+1.
  - ltssm_stable updated at edge k+STABLE_CYC when the input is held constant.
  - A glitch shorter than STABLE_CYC samples never reaches ltssm_stable.
- FSM transition at edge t:
  - link_up changes at t+1.
  - The strobe is low for edges t+1 .. t+PULSE_W.
- dl_up fall from UP: dl_up_r at edge d, FSM transition at d+1, dlup_exit low from d+2.
- Simultaneous dl_up_r fall and ltssm_stable == HOT_RESET in UP: the dlup exit wins and hotrst is not fired.

## Configuration
- PCIE_LINK_EVT_CNT_EN defined: the three 8-bit counters and the evt_cnt_clr port are present.
  - Each counter increments on its fire and saturates at 255.
  - evt_cnt_clr zeroes all three next cycle and wins over a simultaneous increment.
- PCIE_LINK_EVT_CNT_EN undefined: the counters and the evt_cnt_clr port are omitted. All other behaviour is identical.

## Structure
- Shared package pcie_ltssm_pkg holds:
  - the LTSSM localparams: L0 5'h0F, DISABLE 5'h10, HOT_RESET 5'h14, L2_IDLE 5'h18, L2_TX_WAKE 5'h19;
  - the FSM state enum.
- Sub-module pcie_exit_pulse (one instance per strobe) takes fire in and gives an active-low out. Its parameter is PULSE_W, and it contains the reload counter.

## Test plan
- Reset release with ltssm = 5'h0F and dl_up = 1 (defaults): link_up rises after edge 4+2 = 6 relative to first sample; all strobes stay 1.
- From UP, drop dl_up for 10 cycles: dlup_exit is low for exactly 2 cycles starting 2 edges after the dl_up_r fall; link_up = 0.
- From UP, ltssm 0x14 for 20 cycles, then 0x00: hotrst_exit is low for 2 cycles once 0x00 is stable; no dlup_exit even though dl_up falls.
- In UP, a 3-cycle ltssm glitch to 0x14: ltssm_stable stays 0x0F and no strobe fires.
- UP -> 0x18 -> 0x19 -> 0x00: one l2_exit pulse only, on acceptance of 0x00.
- Counter build: 300 dlup events -> evt_dlup_cnt = 255. Then evt_cnt_clr asserted in the same cycle as a fire -> 0.
